// File: rtl/regfile_wport_if.sv
// Write-port sharing bundle: WB, clear-sweep and debug requesters plus the
// register file write port they compete for.
interface regfile_wport_if #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
);
  localparam int ADDR_W = $clog2(REG_NUM);

  logic              wb_we;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_ack;
  logic              dbg_starve;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output wb_we, wb_addr, wb_data, clr_start, dbg_req, dbg_addr, dbg_wdata,
    input  clr_busy, clr_done, dbg_ack, dbg_starve, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  wb_we, wb_addr, wb_data, clr_start, dbg_req, dbg_addr, dbg_wdata,
    output clr_busy, clr_done, dbg_ack, dbg_starve, rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Single register-file write port shared by WB (highest), the clear sweep and
// debug writes; one registered winner per cycle, register 0 never written.
module regfile_wport_arbiter #(
  parameter int DATA_W     = 32,
  parameter int REG_NUM    = 32,
  parameter int STARVE_MAX = 8
) (
  input logic            clk,
  input logic            reset,
  regfile_wport_if.slave bus
);
  localparam int ADDR_W = $clog2(REG_NUM);
  localparam int SCNT_W = 8;

  typedef enum logic { IDLE, CLEAR } state_t;
  typedef enum logic [1:0] { SRC_NONE, SRC_WB, SRC_CLR, SRC_DBG } src_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t            state, state_nxt;
  src_t              src;
  wr_req_t           win;
  logic              swp_last;
  logic              clr_enter;
  logic [ADDR_W-1:0] swp_cnt;
  logic [SCNT_W-1:0] stv_cnt;

  logic              rf_we_q;
  logic [ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;
  logic              dbg_ack_q;
  logic              clr_done_q;

  assign swp_last  = (swp_cnt == ADDR_W'(REG_NUM - 1));
  assign clr_enter = (state == IDLE) && (state_nxt == CLEAR);

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state; a sweep slot lost to WB does not advance toward exit
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clr_start) state_nxt = CLEAR;
      CLEAR:   if (src == SRC_CLR && swp_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: fixed-priority source select and the winning request
  always_comb begin
    src = SRC_NONE;
    if (bus.wb_we)                          src = SRC_WB;
    else if (state == CLEAR)                src = SRC_CLR;
    else if (bus.dbg_req)                   src = SRC_DBG;
  end

  always_comb begin
    win = '0;
    case (src)
      SRC_WB: begin
        win.vld  = 1'b1;
        win.addr = bus.wb_addr;
        win.data = bus.wb_data;
      end
      SRC_CLR: begin
        win.vld  = 1'b1;
        win.addr = swp_cnt;
        win.data = '0;
      end
      SRC_DBG: begin
        win.vld  = 1'b1;
        win.addr = bus.dbg_addr;
        win.data = bus.dbg_wdata;
      end
      default: win = '0;
    endcase
  end

  // Registered write port; an address-0 winner burns the slot with rf_we low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      dbg_ack_q  <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      rf_we_q    <= win.vld && (win.addr != '0);
      dbg_ack_q  <= (src == SRC_DBG);
      clr_done_q <= (src == SRC_CLR) && swp_last;
      if (win.vld) begin
        rf_waddr_q <= win.addr;
        rf_wdata_q <= win.data;
      end
    end
  end

  // Sweep address: starts at 1 since register 0 needs no clearing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               swp_cnt <= ADDR_W'(1);
    else if (clr_enter)       swp_cnt <= ADDR_W'(1);
    else if (src == SRC_CLR)  swp_cnt <= swp_last ? ADDR_W'(1) : swp_cnt + ADDR_W'(1);
  end

  // Starvation: consecutive lost debug cycles, saturating
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               stv_cnt <= '0;
    else if (!bus.dbg_req || src == SRC_DBG)  stv_cnt <= '0;
    else if (stv_cnt != SCNT_W'(STARVE_MAX))  stv_cnt <= stv_cnt + SCNT_W'(1);
  end

  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.dbg_ack    = dbg_ack_q;
  assign bus.clr_done   = clr_done_q;
  assign bus.clr_busy   = (state == CLEAR);
  assign bus.dbg_starve = (stv_cnt == SCNT_W'(STARVE_MAX));
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench for regfile_wport_arbiter: WB, reg0, collision, starvation,
// clear sweeps and reset abort, with hand-computed expectations.
module tb_regfile_wport_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regfile_wport_if #(.DATA_W(32), .REG_NUM(32)) bus();

  regfile_wport_arbiter #(.DATA_W(32), .REG_NUM(32), .STARVE_MAX(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // inputs set before step() are sampled on its edge; outputs checked 1ns later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0;
    bus.clr_start = 0;
    bus.dbg_req = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    repeat (2) step();
    total++; if (bus.rf_we !== 1'b0)      begin bad++; $display("FAIL rst_we act=%b exp=0", bus.rf_we); end
    total++; if (bus.rf_waddr !== 5'd0)   begin bad++; $display("FAIL rst_waddr act=%0d exp=0", bus.rf_waddr); end
    total++; if (bus.rf_wdata !== 32'd0)  begin bad++; $display("FAIL rst_wdata act=%h exp=0", bus.rf_wdata); end
    total++; if (bus.dbg_ack !== 1'b0)    begin bad++; $display("FAIL rst_ack act=%b exp=0", bus.dbg_ack); end
    total++; if (bus.clr_busy !== 1'b0)   begin bad++; $display("FAIL rst_busy act=%b exp=0", bus.clr_busy); end
    total++; if (bus.clr_done !== 1'b0)   begin bad++; $display("FAIL rst_done act=%b exp=0", bus.clr_done); end
    total++; if (bus.dbg_starve !== 1'b0) begin bad++; $display("FAIL rst_starve act=%b exp=0", bus.dbg_starve); end
    #2 reset = 1'b1;
    step();
  endtask

  task automatic test_wb_write();
    bus.wb_we = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
    step();
    total++; if (bus.rf_we !== 1'b1)           begin bad++; $display("FAIL wb_we act=%b exp=1", bus.rf_we); end
    total++; if (bus.rf_waddr !== 5'd5)        begin bad++; $display("FAIL wb_addr act=%0d exp=5", bus.rf_waddr); end
    total++; if (bus.rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wb_data act=%h exp=deadbeef", bus.rf_wdata); end
    bus.wb_we = 0; bus.wb_addr = 5'd9; bus.wb_data = 32'h0;
    step();
    total++; if (bus.rf_we !== 1'b0)           begin bad++; $display("FAIL wb_we_drop act=%b exp=0", bus.rf_we); end
    total++; if (bus.rf_waddr !== 5'd5)        begin bad++; $display("FAIL wb_addr_hold act=%0d exp=5", bus.rf_waddr); end
    total++; if (bus.rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wb_data_hold act=%h exp=deadbeef", bus.rf_wdata); end
  endtask

  task automatic test_reg0();
    bus.wb_we = 1; bus.wb_addr = 5'd0; bus.wb_data = 32'h1111;
    step();
    total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reg0_wb_we act=%b exp=0", bus.rf_we); end
    bus.wb_we = 0;
    bus.dbg_req = 1; bus.dbg_addr = 5'd0; bus.dbg_wdata = 32'h55;
    step();
    total++; if (bus.dbg_ack !== 1'b1) begin bad++; $display("FAIL reg0_dbg_ack act=%b exp=1", bus.dbg_ack); end
    total++; if (bus.rf_we !== 1'b0)   begin bad++; $display("FAIL reg0_dbg_we act=%b exp=0", bus.rf_we); end
    bus.dbg_req = 0;
    step();
    total++; if (bus.dbg_ack !== 1'b0) begin bad++; $display("FAIL reg0_ack_drop act=%b exp=0", bus.dbg_ack); end
  endtask

  task automatic test_collision();
    bus.dbg_req = 1; bus.dbg_addr = 5'd7; bus.dbg_wdata = 32'h1234;
    bus.wb_we = 1; bus.wb_addr = 5'd3;
    for (int i = 0; i < 3; i++) begin
      bus.wb_data = 32'hA0 + i;
      step();
      total++; if (bus.dbg_ack !== 1'b0)     begin bad++; $display("FAIL col_noack[%0d] act=%b exp=0", i, bus.dbg_ack); end
      total++; if (bus.rf_wdata !== 32'hA0 + i) begin bad++; $display("FAIL col_wb[%0d] act=%h exp=%h", i, bus.rf_wdata, 32'hA0 + i); end
    end
    bus.wb_we = 0;
    step();
    total++; if (bus.dbg_ack !== 1'b1)      begin bad++; $display("FAIL col_ack act=%b exp=1", bus.dbg_ack); end
    total++; if (bus.rf_waddr !== 5'd7)     begin bad++; $display("FAIL col_addr act=%0d exp=7", bus.rf_waddr); end
    total++; if (bus.rf_wdata !== 32'h1234) begin bad++; $display("FAIL col_data act=%h exp=1234", bus.rf_wdata); end
    total++; if (bus.rf_we !== 1'b1)        begin bad++; $display("FAIL col_we act=%b exp=1", bus.rf_we); end
    for (int i = 0; i < 2; i++) begin
      bus.dbg_addr = 5'd8 + 5'(i); bus.dbg_wdata = 32'hB0 + i;
      step();
      total++; if (bus.dbg_ack !== 1'b1)       begin bad++; $display("FAIL b2b_ack[%0d] act=%b exp=1", i, bus.dbg_ack); end
      total++; if (bus.rf_waddr !== 5'd8 + 5'(i)) begin bad++; $display("FAIL b2b_addr[%0d] act=%0d exp=%0d", i, bus.rf_waddr, 8 + i); end
      total++; if (bus.rf_wdata !== 32'hB0 + i) begin bad++; $display("FAIL b2b_data[%0d] act=%h exp=%h", i, bus.rf_wdata, 32'hB0 + i); end
    end
    bus.dbg_req = 0;
    step();
    total++; if (bus.dbg_ack !== 1'b0) begin bad++; $display("FAIL b2b_end_ack act=%b exp=0", bus.dbg_ack); end
    total++; if (bus.rf_we !== 1'b0)   begin bad++; $display("FAIL b2b_end_we act=%b exp=0", bus.rf_we); end
  endtask

  task automatic test_starve();
    bus.dbg_req = 1; bus.dbg_addr = 5'd10; bus.dbg_wdata = 32'hBEEF;
    bus.wb_we = 1; bus.wb_addr = 5'd2; bus.wb_data = 32'h2;
    for (int i = 1; i <= 10; i++) begin
      step();
      total++; if (bus.dbg_starve !== (i >= 8)) begin bad++; $display("FAIL starve[%0d] act=%b exp=%b", i, bus.dbg_starve, i >= 8); end
    end
    bus.wb_we = 0;
    step();
    total++; if (bus.dbg_ack !== 1'b1)    begin bad++; $display("FAIL starve_ack act=%b exp=1", bus.dbg_ack); end
    total++; if (bus.dbg_starve !== 1'b0) begin bad++; $display("FAIL starve_clr act=%b exp=0", bus.dbg_starve); end
    total++; if (bus.rf_waddr !== 5'd10)  begin bad++; $display("FAIL starve_addr act=%0d exp=10", bus.rf_waddr); end
    bus.dbg_req = 0;
    step();
  endtask

  task automatic test_sweep();
    bus.clr_start = 1;
    step();
    bus.clr_start = 0;
    total++; if (bus.clr_busy !== 1'b1) begin bad++; $display("FAIL sw_busy0 act=%b exp=1", bus.clr_busy); end
    total++; if (bus.rf_we !== 1'b0)    begin bad++; $display("FAIL sw_we0 act=%b exp=0", bus.rf_we); end
    for (int k = 1; k <= 31; k++) begin
      bus.clr_start = (k == 10);
      step();
      if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'(k) || bus.rf_wdata !== 32'd0) begin
        bad++; $display("FAIL sw_wr[%0d] act=we%b/a%0d/d%h exp=we1/a%0d/d0", k, bus.rf_we, bus.rf_waddr, bus.rf_wdata, k);
      end
      total++;
      total++; if (bus.clr_busy !== (k < 31))  begin bad++; $display("FAIL sw_busy[%0d] act=%b exp=%b", k, bus.clr_busy, k < 31); end
      total++; if (bus.clr_done !== (k == 31)) begin bad++; $display("FAIL sw_done[%0d] act=%b exp=%b", k, bus.clr_done, k == 31); end
    end
    bus.clr_start = 0;
    step();
    total++; if (bus.clr_done !== 1'b0) begin bad++; $display("FAIL sw_done_end act=%b exp=0", bus.clr_done); end
    total++; if (bus.rf_we !== 1'b0)    begin bad++; $display("FAIL sw_we_end act=%b exp=0", bus.rf_we); end
  endtask

  task automatic test_sweep_wb();
    bus.clr_start = 1;
    step();
    bus.clr_start = 0;
    for (int i = 1; i <= 62; i++) begin
      bus.wb_we   = i[0];
      bus.wb_addr = 5'((i % 7) + 1);
      bus.wb_data = 32'h100 + i;
      step();
      if (i[0]) begin
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'((i % 7) + 1) || bus.rf_wdata !== 32'h100 + i) begin
          bad++; $display("FAIL swb_wb[%0d] act=we%b/a%0d/d%h exp=we1/a%0d/d%h", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, (i % 7) + 1, 32'h100 + i);
        end
      end else begin
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'(i / 2) || bus.rf_wdata !== 32'd0) begin
          bad++; $display("FAIL swb_clr[%0d] act=we%b/a%0d/d%h exp=we1/a%0d/d0", i, bus.rf_we, bus.rf_waddr, bus.rf_wdata, i / 2);
        end
      end
      total++;
      total++; if (bus.clr_done !== (i == 62)) begin bad++; $display("FAIL swb_done[%0d] act=%b exp=%b", i, bus.clr_done, i == 62); end
      total++; if (bus.clr_busy !== (i < 62))  begin bad++; $display("FAIL swb_busy[%0d] act=%b exp=%b", i, bus.clr_busy, i < 62); end
    end
    bus.wb_we = 0;
    step();
    total++; if (bus.clr_done !== 1'b0) begin bad++; $display("FAIL swb_done_end act=%b exp=0", bus.clr_done); end
  endtask

  task automatic test_simul();
    bus.dbg_req = 1; bus.dbg_addr = 5'd4; bus.dbg_wdata = 32'h44; bus.clr_start = 1;
    step();
    bus.dbg_req = 0; bus.clr_start = 0;
    total++; if (bus.dbg_ack !== 1'b1)  begin bad++; $display("FAIL sim_ack act=%b exp=1", bus.dbg_ack); end
    total++; if (bus.rf_waddr !== 5'd4) begin bad++; $display("FAIL sim_addr act=%0d exp=4", bus.rf_waddr); end
    total++; if (bus.clr_busy !== 1'b1) begin bad++; $display("FAIL sim_busy act=%b exp=1", bus.clr_busy); end
    repeat (31) step();
    total++; if (bus.clr_done !== 1'b1 || bus.rf_waddr !== 5'd31) begin
      bad++; $display("FAIL sim_sweep_end act=done%b/a%0d exp=done1/a31", bus.clr_done, bus.rf_waddr);
    end
    step();
  endtask

  task automatic test_reset_mid();
    bus.clr_start = 1;
    step();
    bus.clr_start = 0;
    repeat (12) step();
    total++; if (bus.rf_waddr !== 5'd12) begin bad++; $display("FAIL mid_at12 act=%0d exp=12", bus.rf_waddr); end
    #2 reset = 1'b0;
    #1;
    if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0 || bus.clr_busy !== 1'b0 ||
        bus.dbg_ack !== 1'b0 || bus.clr_done !== 1'b0 || bus.dbg_starve !== 1'b0) begin
      bad++; $display("FAIL mid_rst_outs act=we%b/a%0d/busy%b/done%b exp=all0", bus.rf_we, bus.rf_waddr, bus.clr_busy, bus.clr_done);
    end
    total++;
    repeat (2) step();
    total++; if (bus.clr_done !== 1'b0) begin bad++; $display("FAIL mid_no_done act=%b exp=0", bus.clr_done); end
    #2 reset = 1'b1;
    step();
    total++; if (bus.clr_done !== 1'b0 || bus.clr_busy !== 1'b0) begin
      bad++; $display("FAIL mid_post_rel act=done%b/busy%b exp=0/0", bus.clr_done, bus.clr_busy);
    end
    bus.clr_start = 1;
    step();
    bus.clr_start = 0;
    step();
    total++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd1) begin
      bad++; $display("FAIL mid_restart act=we%b/a%0d exp=we1/a1", bus.rf_we, bus.rf_waddr);
    end
    repeat (31) step();
  endtask

  initial begin
    test_reset();
    test_wb_write();
    test_reg0();
    test_collision();
    test_starve();
    test_sweep();
    test_sweep_wb();
    test_simul();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/regfile_wport_arbiter.md
Name: regfile_wport_arbiter

Overview:
- Shares the register file's single write port among three sources:
  - pipeline writeback (WB)
  - a hardware clear-sweep engine
  - a debug/host write interface
- Sits between the WB stage and the register file.
- Drives the register file's write enable, write address and write data from registered outputs.
- Outputs update on posedge clk; the register file captures them on the following negedge.

Parameters:
- DATA_W, 32, register data width.
- REG_NUM, 32, number of architectural registers. ADDR_W = $clog2(REG_NUM), derived, not overridable.
- STARVE_MAX, 8, consecutive blocked debug cycles before dbg_starve asserts. Range 1..255.

Ports:
- clk  input  1  system clock, posedge.
- reset  input  1  asynchronous, active-low.
- wb_we  input  1  WB write request. Highest priority, no backpressure.
- wb_addr  input  ADDR_W  WB destination register.
- wb_data  input  DATA_W  WB write data.
- clr_start  input  1  single-cycle pulse that starts the clear sweep.
- clr_busy  output  1  sweep in progress.
- clr_done  output  1  one-cycle pulse after the last sweep write.
- dbg_req  input  1  debug write request. Held high until dbg_ack.
- dbg_addr  input  ADDR_W  debug destination register.
- dbg_wdata  input  DATA_W  debug write data.
- dbg_ack  output  1  one-cycle pulse: request accepted.
- dbg_starve  output  1  debug request blocked for at least STARVE_MAX consecutive cycles.
- rf_we  output  1  register file write enable.
- rf_waddr  output  ADDR_W  register file write address.
- rf_wdata  output  DATA_W  register file write data.

Behaviour:
- Reset (async, active-low):
  - rf_we, rf_waddr, rf_wdata, dbg_ack, clr_busy, clr_done and dbg_starve all 0.
  - FSM = IDLE; sweep counter = 1; starve counter = 0.
  - Reset asserted mid-sweep aborts the sweep; no clr_done.
- FSM states:
  - IDLE: clr_start=1 -> CLEAR, clr_busy=1 from the next cycle.
  - CLEAR: after the write to address REG_NUM-1 is issued -> IDLE. clr_busy drops and clr_done=1 in the same cycle. clr_start is ignored while in CLEAR.
- Per-cycle arbitration, one winner per cycle:
  - WB wins if wb_we=1.
  - Else the sweep wins if in CLEAR.
  - Else debug wins if dbg_req=1 (IDLE only; debug is never served in CLEAR).
- Output latency:
  - The winner's write appears on rf_* exactly 1 cycle after its inputs are sampled.
  - rf_we is high for one cycle per write.
  - No winner -> rf_we=0; rf_waddr and rf_wdata hold their last values.
- Register 0 is hardwired zero:
  - Any winning write to address 0 drives rf_we=0, but the slot is still consumed.
  - A debug write to address 0 is still acked.
- Sweep:
  - Counter runs 1..REG_NUM-1; each won slot writes 0 to the counter address, then increments.
  - A cycle lost to WB stalls the counter.
  - The total write count is exactly REG_NUM-1.
  - The counter reloads to 1 on entry to CLEAR.
- Debug handshake:
  - dbg_ack is asserted in the same cycle rf_we/rf_waddr/rf_wdata carry the debug write.
  - dbg_req held high in the cycle after the ack is a new request, so back-to-back acks are legal.
  - dbg_addr and dbg_wdata must be stable while dbg_req=1 and un-acked.
- Starvation:
  - The counter increments each cycle dbg_req=1 and debug loses, saturating at STARVE_MAX.
  - dbg_starve=1 while the counter equals STARVE_MAX.
  - The counter clears and dbg_starve drops on dbg_ack or when dbg_req=0.
  - Cycles in CLEAR count as lost.
- Simultaneous events:
  - clr_start together with dbg_req in IDLE: debug is served that cycle and the FSM still enters CLEAR.
  - clr_start together with wb_we: WB is served and the FSM enters CLEAR.

Test Plan:
- Reset released, wb_we=1, wb_addr=5, wb_data=0xDEADBEEF for one cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; following cycle rf_we=0.
- Reg 0 writes: wb_we=1 with wb_addr=0 -> rf_we stays 0. dbg_req with dbg_addr=0 -> dbg_ack=1, rf_we=0.
- Collision then back-to-back debug:
  - dbg_req=1, addr=7, data=0x1234 together with wb_we=1 for 3 cycles -> no ack during those 3 cycles; ack on the 4th output cycle with rf_waddr=7, rf_wdata=0x1234.
  - dbg_req held high with new data -> ack on consecutive cycles.
- Starvation: STARVE_MAX=8, wb_we=1 for 10 cycles with dbg_req=1 -> dbg_starve rises after 8 blocked cycles, stays high, and clears in the cycle dbg_ack pulses.
- Clear sweep:
  - clr_start with no WB traffic -> 31 writes of 0 to addresses 1..31 on consecutive cycles, then a clr_done pulse and clr_busy=0.
  - Repeat with wb_we every other cycle -> sweep takes 62 cycles, no address skipped or repeated, and WB writes interleave correctly.
- Reset mid-sweep: assert reset at sweep address 12 -> all outputs 0 immediately, no clr_done. A new clr_start restarts the sweep from address 1.
